// File: rtl/fp_result_buffer_if.sv
// Ready/valid result stream leaving the buffer: data word plus its class flags.
interface fp_result_buffer_if;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_flags;

    modport master (output m_valid, output m_data, output m_flags, input m_ready);
    modport slave  (input m_valid, input m_data, input m_flags, output m_ready);
endinterface

// File: rtl/fp_result_buffer.sv
// Result FIFO behind a backpressure-free FP adder, with IEEE-754 class tagging
// and an issue-credit scheme that guarantees every launched op a slot on return.
module fp_result_buffer #(
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue,
    output logic                issue_ok,
    input  logic                fp_valid,
    input  logic [31:0]         fp_result,
    fp_result_buffer_if.master  m,
    output logic [CNT_W-1:0]    count,
    output logic [CNT_W-1:0]    inflight,
    output logic [1:0]          err
);
    localparam int ADDR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0]  flags;
        logic [31:0] data;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr, rd_ptr;
    logic               pop, push;
    logic [CNT_W:0]     committed;
    logic [CNT_W:0]     inflight_sum;
    logic [CNT_W-1:0]   inflight_next;

    function automatic logic [3:0] classify(input logic [31:0] v);
        logic [7:0]  e;
        logic [22:0] f;
        e = v[30:23];
        f = v[22:0];
        return {(e == 8'hFF) && (f != '0),
                (e == 8'hFF) && (f == '0),
                (e == 8'h00) && (f == '0),
                v[31]};
    endfunction

    assign m.m_valid = (count != '0);
    assign m.m_data  = mem[rd_ptr].data;
    assign m.m_flags = mem[rd_ptr].flags;

    always_comb begin
        pop          = m.m_valid && m.m_ready;
        // A full FIFO still accepts when the head leaves in the same cycle.
        push         = fp_valid && ((count < CNT_W'(DEPTH)) || pop);
        committed    = {1'b0, count} + {1'b0, inflight};
        issue_ok     = committed < (CNT_W+1)'(DEPTH);
        // Returns with no outstanding credit (e.g. after reset) do not underflow.
        inflight_sum = {1'b0, inflight} + (CNT_W+1)'(issue)
                     - (CNT_W+1)'(fp_valid && (inflight != '0));
        inflight_next = (inflight_sum > (CNT_W+1)'(DEPTH)) ? CNT_W'(DEPTH)
                                                           : inflight_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            inflight <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            err      <= '0;
        end else begin
            count    <= count + CNT_W'(push) - CNT_W'(pop);
            inflight <= inflight_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (issue && !issue_ok) err[1] <= 1'b1;
            if (fp_valid && !push)  err[0] <= 1'b1;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= '{flags: classify(fp_result), data: fp_result};
    end
endmodule

// File: tb/tb_fp_result_buffer.sv
// Directed plus randomized bench for fp_result_buffer against a queue-based model.
module tb_fp_result_buffer;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst, issue, fp_valid;
    logic [31:0]      fp_result;
    logic             issue_ok;
    logic [CNT_W-1:0] count, inflight;
    logic [1:0]       err;

    fp_result_buffer_if bus ();

    fp_result_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .issue(issue), .issue_ok(issue_ok),
        .fp_valid(fp_valid), .fp_result(fp_result), .m(bus),
        .count(count), .inflight(inflight), .err(err)
    );

    always #5 clk = ~clk;

    int          npass = 0, nchk = 0;
    logic [35:0] q[$];
    int          minf = 0;
    logic [1:0]  merr = '0;

    logic [31:0] fvec [5] = '{32'h7FC00000, 32'hFF800000, 32'h00000000, 32'h80000000, 32'h00000001};
    logic [3:0]  fexp [5] = '{4'b1000, 4'b0101, 4'b0010, 4'b0011, 4'b0000};

    // Class by magnitude ordering of the bit pattern.
    function automatic logic [3:0] cls(input logic [31:0] x);
        logic [31:0] mag;
        mag = x & 32'h7FFF_FFFF;
        return {mag > 32'h7F80_0000, mag == 32'h7F80_0000, mag == 32'h0, x[31]};
    endfunction

    function automatic bit m_ok();
        return (q.size() + minf) < DEPTH;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cycle();
        bit pop, acc;
        int ni;
        if (rst) begin
            q.delete();
            minf = 0;
            merr = '0;
        end else begin
            if (issue && !m_ok()) merr[1] = 1'b1;
            ni = minf + int'(issue) - ((fp_valid && minf > 0) ? 1 : 0);
            if (ni > DEPTH) ni = DEPTH;
            pop = (q.size() > 0) && m_ready_q();
            acc = fp_valid && (q.size() < DEPTH || pop);
            if (fp_valid && !acc) merr[0] = 1'b1;
            if (pop) void'(q.pop_front());
            if (acc) q.push_back({cls(fp_result), fp_result});
            minf = ni;
        end
        @(posedge clk);
        #1;
        chk("count", count, q.size());
        chk("inflight", inflight, minf);
        chk("err", err, merr);
        chk("m_valid", bus.m_valid, q.size() > 0);
        chk("issue_ok", issue_ok, m_ok());
        if (q.size() > 0) begin
            chk("m_data", bus.m_data, q[0][31:0]);
            chk("m_flags", bus.m_flags, q[0][35:32]);
        end
    endtask

    function automatic bit m_ready_q();
        return bus.m_ready;
    endfunction

    task automatic idle();
        issue = 1'b0;
        fp_valid = 1'b0;
    endtask

    task automatic drain();
        idle();
        bus.m_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) cycle();
        chk("drained", count, 0);
    endtask

    int issued;

    initial begin
        rst = 1'b1; issue = 1'b0; fp_valid = 1'b0; fp_result = '0; bus.m_ready = 1'b0;
        cycle();
        chk("rst_issue_ok", issue_ok, 1);
        rst = 1'b0;
        cycle();

        // Basic round trip
        issue = 1'b1; cycle();
        chk("one_inflight", inflight, 1);
        issue = 1'b0; fp_valid = 1'b1; fp_result = 32'h40400000; cycle();
        fp_valid = 1'b0;
        chk("rt_inflight", inflight, 0);
        chk("rt_data", bus.m_data, 32'h40400000);
        chk("rt_flags", bus.m_flags, 4'b0000);
        bus.m_ready = 1'b1; cycle();
        chk("rt_popped", count, 0);

        // Credit fill with stalled consumer, twice for pointer wrap
        for (int rep = 0; rep < 2; rep++) begin
            bus.m_ready = 1'b0;
            issued = 0;
            for (int i = 0; i < 12; i++) begin
                issue = m_ok();
                if (issue) issued++;
                fp_valid = (minf > 0);
                fp_result = $urandom;
                cycle();
            end
            chk("issues_to_full", issued, DEPTH);
            chk("issue_ok_low", issue_ok, 0);
            issue = 1'b0;
            for (int i = 0; i < DEPTH && minf > 0; i++) begin
                fp_valid = 1'b1; fp_result = $urandom; cycle();
            end
            chk("fill_count", count, DEPTH);
            drain();
            chk("fill_err", err, 0);
        end

        // Class flags
        for (int i = 0; i < 5; i++) begin
            bus.m_ready = 1'b0; fp_valid = 1'b1; fp_result = fvec[i]; cycle();
            chk("class_flags", bus.m_flags, fexp[i]);
            fp_valid = 1'b0; bus.m_ready = 1'b1; cycle();
        end

        // Push and pop together while full
        idle(); bus.m_ready = 1'b0; fp_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin fp_result = $urandom; cycle(); end
        bus.m_ready = 1'b1; fp_result = 32'h3F800000; cycle();
        chk("full_pushpop_count", count, DEPTH);
        chk("full_pushpop_err", err, 0);
        drain();

        // Issue and return together
        issue = 1'b1; cycle();
        fp_valid = 1'b1; fp_result = 32'hC0000000; cycle();
        chk("issue_ret_inflight", inflight, 1);
        issue = 1'b0; cycle();
        drain();

        // Misuse: over-issue, then overflow
        bus.m_ready = 1'b0; issue = 1'b1;
        for (int i = 0; i < DEPTH; i++) cycle();
        cycle();
        chk("over_issue_err", err, 2'b10);
        chk("over_issue_sat", inflight, DEPTH);
        issue = 1'b0; fp_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin fp_result = $urandom; cycle(); end
        fp_result = 32'h12345678; cycle();
        chk("overflow_err", err, 2'b11);
        chk("overflow_count", count, DEPTH);
        idle(); rst = 1'b1; cycle(); rst = 1'b0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            issue = m_ok() ? 1'($urandom % 2) : 1'($urandom % 16 == 0);
            fp_valid = (minf > 0) ? 1'($urandom % 2) : 1'($urandom % 20 == 0);
            fp_result = ($urandom % 8 == 0) ? fvec[$urandom % 5] : $urandom;
            bus.m_ready = 1'($urandom % 3 != 0);
            cycle();
        end
        idle(); rst = 1'b1; cycle(); rst = 1'b0;

        // Reset mid-operation
        bus.m_ready = 1'b0; issue = 1'b1;
        for (int i = 0; i < 7; i++) cycle();
        issue = 1'b0; fp_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin fp_result = $urandom; cycle(); end
        idle();
        chk("pre_rst_count", count, 5);
        chk("pre_rst_inflight", inflight, 2);
        rst = 1'b1; cycle(); rst = 1'b0;
        chk("post_rst_count", count, 0);
        chk("post_rst_inflight", inflight, 0);
        chk("post_rst_m_valid", bus.m_valid, 0);
        chk("post_rst_err", err, 0);
        chk("post_rst_issue_ok", issue_ok, 1);
        fp_valid = 1'b1; fp_result = 32'h00000001; cycle();
        chk("late_return_inflight", inflight, 0);
        chk("late_return_count", count, 1);
        idle(); cycle();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/fp_result_buffer.md
Name: fp_result_buffer

Overview:
- Sits directly downstream of fp_adder_pipeline, which has no backpressure. Captures every result/valid_out pulse into a FIFO and presents it on a ready/valid master interface.
- Tags each result with IEEE-754 class flags.
- Runs a credit scheme toward the issuing logic. `issue_ok` is high only when a newly launched adder operation is guaranteed a FIFO slot when it completes, so no result is ever dropped.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH)+1, width of occupancy/in-flight counters (derived, not overridden).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- issue  input  1  upstream launched one op into the adder this cycle (same cycle as adder valid_in).
- issue_ok  output  1  upstream may issue this cycle.
- fp_valid  input  1  adder valid_out.
- fp_result  input  32  adder result.
- m_valid  output  1  head entry available.
- m_ready  input  1  consumer accepts head.
- m_data  output  32  head result.
- m_flags  output  4  head class {nan, inf, zero, sign}.
- count  output  CNT_W  FIFO occupancy.
- inflight  output  CNT_W  ops issued but not yet returned.
- err  output  2  sticky {issue_err, drop_err}.

Behaviour:
Reset:
- Synchronous on rst=1: count=0, inflight=0, pointers=0, err=0, m_valid=0.
- m_data/m_flags are don't-care while m_valid=0.
- Reset mid-operation discards stored entries and in-flight credit. Results returning after reset arrive with inflight=0 and are handled as the boundary case below.

Credit:
- `issue_ok = (count + inflight) < DEPTH`, combinational from registers only; no dependence on same-cycle issue or m_ready.
- `inflight_next = inflight + issue − fp_valid`, each term 0/1. Simultaneous issue and fp_valid leaves inflight unchanged.
- issue while issue_ok=0: sets err[1], still increments inflight (saturating at DEPTH).
- fp_valid while inflight=0: decrement suppressed (no underflow); the result is still pushed if space exists.

FIFO:
- Push on fp_valid, accepted if count<DEPTH, or if count==DEPTH and a pop occurs the same cycle.
- Otherwise the result is dropped and err[0] is set.
- Pop on m_valid && m_ready.
- Push and pop in the same cycle leave count unchanged.
- First-word fall-through: `m_valid = (count != 0)`; m_data/m_flags driven from the head entry.
- A pushed result is visible on the master interface the cycle after fp_valid is sampled (1-cycle latency). Into an empty FIFO, it is never bypassed combinationally.
- m_data/m_flags stay stable while m_valid && !m_ready.
- Pointers are ADDR_W=$clog2(DEPTH) bits and wrap naturally at DEPTH.

Flags:
- Computed at push from fp_result and stored with the entry. With e=[30:23], f=[22:0]:
  - nan  = (e==8'hFF && f!=0)
  - inf  = (e==8'hFF && f==0)
  - zero = (e==0 && f==0)
  - sign = bit31
- Subnormals set none of nan/inf/zero.

Errors:
- err bits are sticky until rst; they never block operation.

Invariant:
- With well-behaved upstream (issue only when issue_ok), count+inflight ≤ DEPTH always and err stays 0.

Test Plan:
1. Reset, then issue 1 op; fp_valid with fp_result=0x40400000 → inflight 1→0; the next cycle m_valid=1, m_data=0x40400000, m_flags=4'b0000; pop with m_ready=1 → count=0.
2. Hold m_ready=0 and issue whenever issue_ok, returning results in sequence → issue_ok falls after exactly 8 issues (count+inflight=8). Then release m_ready → outputs emerge in order with no err. Fill 8 entries, drain, refill 8 to cover pointer wrap.
3. Class flags: push 0x7FC00000 → flags 1000; 0xFF800000 → 0101; 0x00000000 → 0010; 0x80000000 → 0011; 0x00000001 → 0000.
4. Simultaneous events:
   - With count=8, fp_valid and pop in the same cycle → accepted, count stays 8, err=0.
   - Issue and fp_valid in the same cycle → inflight unchanged.
5. Misuse:
   - issue while issue_ok=0 → err=2'b10.
   - fp_valid with FIFO full and m_ready=0 → result dropped, err[0]=1, count stays 8.
   - fp_valid with inflight=0 → inflight stays 0, result stored.
6. Assert rst with count=5 and inflight=2 → next cycle count=0, inflight=0, m_valid=0, err=0, issue_ok=1.
